// File: rtl/clock_div.sv
// Run-time programmable clock divider: one-cycle tick every DIV cycles plus a
// 50% square wave, with glitch-free divisor reload at period boundaries.
module clock_div #(
    parameter int unsigned WIDTH       = 26,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic             tick,
    output logic             square,
    output logic [WIDTH-1:0] count,
    output logic             div_pending
);

    localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DEF_DIV_C = (DEFAULT_DIV == 0) ? ONE_C : WIDTH'(DEFAULT_DIV);

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}}) ? ONE_C : v;
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic [WIDTH-1:0] div_next_q, div_next_d;
    logic             div_pending_q, div_pending_d;
    logic             tick_q, tick_d;
    logic             square_q, square_d;
    logic             tc_s;

    // div_active_q is never 0, so the subtraction cannot underflow.
    assign tc_s = enable && (count_q == (div_active_q - ONE_C));

    // Next-state logic: sync_clr beats terminal count beats normal counting.
    always_comb begin
        count_d       = count_q;
        div_active_d  = div_active_q;
        div_next_d    = div_next_q;
        div_pending_d = div_pending_q;
        tick_d        = 1'b0;
        square_d      = square_q;
        if (sync_clr || tc_s) begin
            if (sync_clr) begin
                square_d = 1'b0;
            end else begin
                tick_d   = 1'b1;
                square_d = ~square_q;
            end
            count_d       = {WIDTH{1'b0}};
            div_pending_d = 1'b0;
            if (div_load) begin
                div_active_d = clamp_div(div_value);
            end else if (div_pending_q) begin
                div_active_d = div_next_q;
            end else begin
                div_active_d = div_active_q;
            end
        end else begin
            if (enable) begin
                count_d = count_q + ONE_C;
            end else begin
                count_d = count_q;
            end
            if (div_load) begin
                div_next_d    = clamp_div(div_value);
                div_pending_d = 1'b1;
            end else begin
                div_next_d    = div_next_q;
                div_pending_d = div_pending_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q       <= {WIDTH{1'b0}};
            div_active_q  <= DEF_DIV_C;
            div_next_q    <= DEF_DIV_C;
            div_pending_q <= 1'b0;
            tick_q        <= 1'b0;
            square_q      <= 1'b0;
        end else begin
            count_q       <= count_d;
            div_active_q  <= div_active_d;
            div_next_q    <= div_next_d;
            div_pending_q <= div_pending_d;
            tick_q        <= tick_d;
            square_q      <= square_d;
        end
    end

    assign tick        = tick_q;
    assign square      = square_q;
    assign count       = count_q;
    assign div_pending = div_pending_q;

endmodule
